// File: rtl/sliced_logic_pkg.sv
// sliced_logic_pkg: shared op/state encodings for the sliced logic unit.
// Rev 1.0
`default_nettype none

package sliced_logic_pkg;

  typedef enum logic [2:0] {
    LOP_AND  = 3'd0,
    LOP_OR   = 3'd1,
    LOP_XOR  = 3'd2,
    LOP_NOR  = 3'd3,
    LOP_NAND = 3'd4,
    LOP_XNOR = 3'd5,
    LOP_ANDN = 3'd6,
    LOP_NOTA = 3'd7
  } lop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sliced_logic_unit_slice.sv
// logic_slice: combinational eight-way bitwise function over one SLICE-bit chunk.
// Rev 1.0
`default_nettype none

module logic_slice
  import sliced_logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  lop_e             op,
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  output logic [SLICE-1:0] y_s
);

  always_comb begin
    y_s = '0;
    case (op)
      LOP_AND:  y_s = a_s & b_s;
      LOP_OR:   y_s = a_s | b_s;
      LOP_XOR:  y_s = a_s ^ b_s;
      LOP_NOR:  y_s = ~(a_s | b_s);
      LOP_NAND: y_s = ~(a_s & b_s);
      LOP_XNOR: y_s = ~(a_s ^ b_s);
      LOP_ANDN: y_s = a_s & ~b_s;
      LOP_NOTA: y_s = ~a_s;
      default:  y_s = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sliced_logic_unit.sv
// sliced_logic_unit: WIDTH-bit bitwise logic engine, SLICE bits per cycle, valid/ready on both sides.
// Rev 1.0
`default_nettype none

module sliced_logic_unit
  import sliced_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  lop_e             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [31:0]      slice_base;
  logic [SLICE-1:0] a_s, b_s, y_s;
  logic             accept;

  assign slice_base = 32'(idx_q) * SLICE;
  assign a_s        = a_q[slice_base +: SLICE];
  assign b_s        = b_q[slice_base +: SLICE];
  assign accept     = (state_q == IDLE) && in_valid && !flush;

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op  (op_q),
    .a_s (a_s),
    .b_s (b_s),
    .y_s (y_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = RUN;
        RUN:     if (idx_q == LAST_IDX) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: operand capture, slice write-back and index advance
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    if (flush) begin
      idx_d = '0;
    end else if (accept) begin
      a_d      = a;
      b_d      = b;
      op_d     = lop_e'(op);
      idx_d    = '0;
      result_d = '0;
    end else if (state_q == RUN) begin
      result_d[slice_base +: SLICE] = y_s;
      // Return to zero on the last slice so idx never wraps past NSLICE-1
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= LOP_AND;
      result_q <= '0;
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign zero   = ~|result_q;

endmodule

`default_nettype wire
